// File: rtl/noc_types_pkg.sv
// Shared NoC types: flit format, arbiter FSM states and port count.
package noc_types;

    localparam int unsigned NOC_PORTS      = 5;
    localparam int unsigned FLIT_PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'b00,
        FLIT_DATA   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_RSVD   = 2'b11
    } e_flit_type;

    typedef struct packed {
        e_flit_type                flit_type;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} e_arb_state;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo N.
module noc_rr_pick #(
    parameter int unsigned N = 5,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int unsigned k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr < N, so a single subtraction wraps correctly for any N
            k = 32'(ptr) + off;
            if (k >= N) k = k - N;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = W'(k);
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output-port wormhole arbiter with a registered one-entry output stage.
// Optional protocol checker (proto_err) enabled by defining NOC_ARB_PROTO_CHK_EN.
module noc_out_arbiter
    import noc_types::*;
#(
    parameter int unsigned N_IN = NOC_PORTS,
    parameter int unsigned RR_W = $clog2(N_IN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IN-1:0]     in_valid,
    input  flit_t [N_IN-1:0]    in_flit,
    output logic [N_IN-1:0]     in_ready,
    output logic                out_valid,
    output flit_t               out_flit,
    input  logic                out_ready,
    output logic [RR_W-1:0]     grant_idx,
    output logic                locked
`ifdef NOC_ARB_PROTO_CHK_EN
    ,
    output logic                proto_err
`endif
);

    e_arb_state      state, state_nxt;
    logic [RR_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [N_IN-1:0] hdr_req, pick_gnt;
    logic [RR_W-1:0] pick_idx, sel_idx;
    logic            pick_any, slot_free, acc;
    flit_t           acc_flit;

    always_comb begin
        hdr_req = '0;
        for (int unsigned i = 0; i < N_IN; i++)
            hdr_req[i] = in_valid[i] && (in_flit[i].flit_type == FLIT_HEADER);
    end

    noc_rr_pick #(
        .N (N_IN),
        .W (RR_W)
    ) u_pick (
        .req (hdr_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        in_ready   = '0;
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_idx;
        sel_idx    = grant_idx;
        case (state)
            ARB_IDLE: begin
                sel_idx = pick_idx;
                if (pick_any && slot_free) in_ready = pick_gnt;
            end
            ARB_LOCKED: in_ready[grant_idx] = slot_free;
        endcase

        acc_flit = in_flit[sel_idx];
        acc      = |(in_valid & in_ready);

        if (acc) begin
            if (state == ARB_IDLE) begin
                state_nxt = ARB_LOCKED;
                grant_nxt = pick_idx;
            end else if (acc_flit.flit_type == FLIT_TAIL) begin
                state_nxt  = ARB_IDLE;
                rr_ptr_nxt = (grant_idx == RR_W'(N_IN - 1)) ? '0 : grant_idx + RR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_idx <= grant_nxt;
            if (acc) begin
                out_flit  <= acc_flit;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign locked = (state == ARB_LOCKED);

`ifdef NOC_ARB_PROTO_CHK_EN
    logic idle_bad, locked_bad;

    always_comb begin
        idle_bad   = (state == ARB_IDLE) && |(in_valid & ~hdr_req);
        locked_bad = (state == ARB_LOCKED) && acc &&
                     ((acc_flit.flit_type == FLIT_HEADER) || (acc_flit.flit_type == FLIT_RSVD));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                      proto_err <= 1'b0;
        else if (idle_bad || locked_bad) proto_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Scoreboard bench for noc_out_arbiter: queued per-input sources, expected-flit queue, output monitor.
module tb_noc_out_arbiter;
    import noc_types::*;

    localparam int unsigned N = 5;
    localparam int unsigned W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     in_valid;
    flit_t [N-1:0]    in_flit;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    flit_t            out_flit;
    logic             out_ready;
    logic [W-1:0]     grant_idx;
    logic             locked;
`ifdef NOC_ARB_PROTO_CHK_EN
    logic             proto_err;
`endif

    typedef struct {
        flit_t       f;
        int unsigned src;
    } exp_t;

    flit_t src_q [N][$];
    exp_t  exp_q [$];
    int    n_cmp = 0;
    int    n_err = 0;

    logic [N-1:0] acc_v;
    logic         acc_pend = 1'b0;
    flit_t        acc_f;

    noc_out_arbiter #(
        .N_IN (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .locked    (locked)
`ifdef NOC_ARB_PROTO_CHK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic e_flit_type ftype(input int unsigned i, input int unsigned len);
        if (i == 0)       return FLIT_HEADER;
        if (i == len - 1) return FLIT_TAIL;
        return FLIT_DATA;
    endfunction

    function automatic flit_t mkf(input e_flit_type t, input int unsigned src,
                                  input int unsigned pkt, input int unsigned seq);
        flit_t f;
        f.flit_type = t;
        f.payload   = {8'hA5, 8'(pkt), 8'(src), 8'(seq)};
        return f;
    endfunction

    task automatic send_pkt(input int unsigned src, input int unsigned len, input int unsigned pkt);
        for (int unsigned i = 0; i < len; i++)
            src_q[src].push_back(mkf(ftype(i, len), src, pkt, i));
    endtask

    task automatic expect_pkt(input int unsigned src, input int unsigned len, input int unsigned pkt);
        exp_t e;
        for (int unsigned i = 0; i < len; i++) begin
            e.f   = mkf(ftype(i, len), src, pkt, i);
            e.src = src;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int unsigned cyc;
        bit busy;
        cyc = 0;
        do begin
            @(negedge clk); #2;
            busy = (exp_q.size() > 0) || out_valid;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1'b1;
            cyc++;
        end while (busy && cyc < 200);
        check({name, "_drained"}, 64'(busy), 64'd0);
        check({name, "_idle_locked"}, 64'(locked), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_flit",  64'(out_flit),  64'd0);
        check("rst_locked",    64'(locked),    64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
    endtask

    // Source driver: presents queue heads at negedge, pops what the DUT accepted at posedge.
    initial begin
        in_valid = '0;
        in_flit  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    in_flit[i]  = src_q[i][0];
                end else begin
                    in_valid[i] = 1'b0;
                    in_flit[i]  = '0;
                end
            end
            #1;
            acc_v = in_valid & in_ready;
            @(posedge clk);
            acc_pend = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (acc_v[i] && src_q[i].size() > 0) begin
                    acc_f    = src_q[i].pop_front();
                    acc_pend = 1'b1;
                end
            end
        end
    end

    // Output monitor: latency, stall stability and in-order scoreboard checks.
    initial begin
        logic  pv, pr;
        flit_t pf;
        exp_t  e;
        pv = 1'b0;
        pr = 1'b1;
        pf = '0;
        forever begin
            @(negedge clk); #3;
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (acc_pend) begin
                check("latency_valid", 64'(out_valid), 64'd1);
                check("latency_flit",  64'(out_flit),  64'(acc_f));
            end
            if (pv && !pr) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_flit",  64'(out_flit),  64'(pf));
            end
            if (out_valid && !out_ready)
                check("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_flit: got %0h expected none", out_flit);
                end else begin
                    e = exp_q.pop_front();
                    check("flit", 64'(out_flit), 64'(e.f));
                    if (e.f.flit_type != FLIT_TAIL) begin
                        check("locked",    64'(locked),    64'd1);
                        check("grant_idx", 64'(grant_idx), 64'(e.src));
                    end
                end
            end
            pv = out_valid;
            pr = out_ready;
            pf = out_flit;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        out_ready = 1'b1;
        do_reset();

        // single packet on input 2
        send_pkt(2, 3, 1);
        expect_pkt(2, 3, 1);
        wait_drain("t1");

        // rr_ptr is 3: input 3 beats input 0; then wrap to input 0
        send_pkt(0, 2, 2);
        send_pkt(3, 2, 3);
        expect_pkt(3, 2, 3);
        expect_pkt(0, 2, 2);
        wait_drain("t1_rr");

        // simultaneous headers from reset: order 0, 1, 4, no interleave
        do_reset();
        send_pkt(0, 3, 4);
        send_pkt(1, 3, 5);
        send_pkt(4, 3, 6);
        expect_pkt(0, 3, 4);
        expect_pkt(1, 3, 5);
        expect_pkt(4, 3, 6);
        wait_drain("t2");

        // input 3 held off while input 1 is locked
        send_pkt(1, 4, 7);
        expect_pkt(1, 4, 7);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #2;
            if (locked) seen = 1'b1;
        end
        check("t3_lock_seen", 64'(seen), 64'd1);
        send_pkt(3, 2, 8);
        expect_pkt(3, 2, 8);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #2;
            if (src_q[1].size() > 0) begin
                check("t3_hold_in_ready3", 64'(in_ready[3]), 64'd0);
            end else begin
                check("t3_release_in_ready3", 64'(in_ready[3]), 64'd1);
                seen = 1'b1;
            end
        end
        check("t3_release_seen", 64'(seen), 64'd1);
        wait_drain("t3");

        // 4-cycle output stall during a DATA flit
        send_pkt(4, 4, 9);
        expect_pkt(4, 4, 9);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #2;
            if (out_valid && out_flit.flit_type == FLIT_DATA) seen = 1'b1;
        end
        check("t4_data_seen", 64'(seen), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        wait_drain("t4");

        // move rr_ptr to 4, then a lone request on input 0 wraps; rr_ptr becomes 1
        send_pkt(3, 2, 10);
        expect_pkt(3, 2, 10);
        wait_drain("t5_setup");
        send_pkt(0, 3, 11);
        expect_pkt(0, 3, 11);
        wait_drain("t5");
        send_pkt(0, 2, 12);
        send_pkt(1, 2, 13);
        expect_pkt(1, 2, 13);
        expect_pkt(0, 2, 12);
        wait_drain("t5_rr");

        // DATA in IDLE is stalled, never forwarded
        do_reset();
        src_q[3].push_back(mkf(FLIT_DATA, 3, 14, 0));
        @(negedge clk); #2;
`ifdef NOC_ARB_PROTO_CHK_EN
        check("t6_proto_err_pre", 64'(proto_err), 64'd0);
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #2;
            check("t6_stall_in_ready3", 64'(in_ready[3]), 64'd0);
            check("t6_no_out_valid",    64'(out_valid),   64'd0);
`ifdef NOC_ARB_PROTO_CHK_EN
            check("t6_proto_err_set",   64'(proto_err),   64'd1);
`endif
        end
        src_q[3].delete();
        repeat (2) @(negedge clk);
        #2;
`ifdef NOC_ARB_PROTO_CHK_EN
        check("t6_proto_err_sticky", 64'(proto_err), 64'd1);
`endif
        do_reset();
`ifdef NOC_ARB_PROTO_CHK_EN
        check("t6_proto_err_cleared", 64'(proto_err), 64'd0);
`endif
        check("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Per-output-port wormhole arbiter for the mesh router. It shares one output link between `N_IN` input ports (N, S, E, W, local) using round-robin arbitration on HEADER flits. It locks the grant to the winning input until that packet's TAIL flit has been transferred. Output is a registered one-entry pipeline stage driving the link with valid/ready flow control.

## Interface
Parameters:
- `N_IN`, default 5, number of competing input ports (range 2..8).
- `RR_W`, default `$clog2(N_IN)`, width of the round-robin pointer and grant index (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  `N_IN`  input i presents a flit.
- `in_flit`  in  `N_IN` x `flit_t`  flit from input i (`noc_types::flit_t`).
- `in_ready`  out  `N_IN`  flit on input i is accepted this cycle.
- `out_valid`  out  1  `out_flit` holds a valid flit.
- `out_flit`  out  `flit_t`  registered output flit.
- `out_ready`  in  1  downstream accepts `out_flit`.
- `grant_idx`  out  `RR_W`  index of the currently locked input; only meaningful while `locked`=1.
- `locked`  out  1  a packet is in flight (FSM in LOCKED).

## Operation
- The FSM has two states: IDLE and LOCKED.
- Definitions:
  - `slot_free` = `!out_valid || out_ready`.
  - Accept on input i: `in_valid[i] && in_ready[i]`.
- IDLE:
  - Candidates are inputs with `in_valid` high and `flit_type`=HEADER.
  - The winner is the first candidate at or after `rr_ptr`, searching upward with wrap-around modulo `N_IN`.
  - `in_ready[winner]` = `slot_free`. All other `in_ready` are 0.
  - On accept: state goes to LOCKED, `grant_idx` becomes the winner, the flit is loaded into the output register.
  - DATA, TAIL and reserved flits presented in IDLE are never accepted; they are stalled.
- LOCKED:
  - `in_ready[grant_idx]` = `slot_free`. All other `in_ready` are 0.
  - Any flit type from the granted input is forwarded unchanged, HEADER included.
  - On accept of a TAIL: state goes to IDLE and `rr_ptr` becomes `(grant_idx+1) mod N_IN`.
- Output register:
  - On an accept, `out_flit` is loaded and `out_valid` is set to 1.
  - Otherwise, if `out_ready` is high, `out_valid` is cleared to 0.
  - `out_flit` holds its value while `out_valid && !out_ready`.
- Wrap-around: the `rr_ptr` increment from `N_IN-1` goes to 0. It must be correct for non-power-of-2 `N_IN`.

## Timing
- Values after reset: state IDLE, `rr_ptr`=0, `grant_idx`=0, `locked`=0, `out_valid`=0, `out_flit`=0, `in_ready`=0.
- Latency from input accept to `out_valid` is 1 cycle. Throughput is one flit per cycle when `out_ready` is held high.
- `in_ready` is combinational from the state, `in_valid`, `in_flit.flit_type`, `out_valid` and `out_ready`. `out_valid` and `out_flit` are registered only.
- TAIL accepted in cycle t: the FSM is IDLE in t+1, and a new HEADER can be accepted in t+1. There is no bubble.
- `out_ready` low with `out_valid` high: all `in_ready` are 0 and the output is held stable.
- `rst_n` low mid-packet: the next edge returns to the reset values and the in-flight flit is discarded. Packet recovery is the responsibility of the downstream side.
- The arbiter never releases the lock on anything other than an accepted TAIL. There is no timeout.

## Configuration
- `NOC_ARB_PROTO_CHK_EN` defined:
  - Adds output port `proto_err` (out, 1, sticky; reset value 0).
  - `proto_err` is set on either of:
    - in IDLE, any input presents `in_valid` with a non-HEADER flit;
    - in LOCKED, an accepted flit of type HEADER or reserved (2'b11).
  - `proto_err` is cleared only by reset. Forwarding behaviour is unchanged.
- `NOC_ARB_PROTO_CHK_EN` undefined: the port and its logic are absent.

## Structure
- Add to `noc_types`:
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} e_arb_state`;
  - a constant `NOC_PORTS` = 5, used as the default for `N_IN`.
- Sub-module `noc_rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, binary index and an `any` flag.
  - It is reusable by the future VC allocator.

## Test plan
- Reset, then input 2 sends HEADER/DATA/TAIL with `out_ready`=1:
  - `out_valid` rises 1 cycle after each accept;
  - the flits appear in order with identical payloads;
  - `locked`=1, `grant_idx`=2 during the packet;
  - `rr_ptr`=3 after the TAIL.
- Inputs 0, 1 and 4 all present HEADERs simultaneously from reset, each sending a 3-flit packet:
  - grant order is 0, 1, 4;
  - there is no interleaving of flits between packets.
- Input 1 is locked mid-packet and input 3 raises a HEADER: `in_ready[3]` stays 0 until the cycle after input 1's TAIL is accepted.
- `out_ready` is held 0 for 4 cycles during a DATA flit: `out_flit` stays stable, all `in_ready` are 0, and no flit is lost or duplicated.
- `N_IN`=5, `rr_ptr`=4, only input 0 requesting: input 0 is granted, and after its TAIL `rr_ptr`=1.
- With `NOC_ARB_PROTO_CHK_EN` defined, input 3 presents a DATA flit in IDLE: `proto_err`=1 the next cycle and stays 1 until `rst_n`=0.
